// File: rtl/mult_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Constants shared by the shift-add multiplier control path,
//               its datapath and the iteration counter.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    // One multiply takes 2**MULT_CNT_WIDTH iterations.
    localparam int MULT_CNT_WIDTH = 3;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mult_counter
// Description : Iteration counter for the shift-add multiplier control path.
//               A load restarts a WIDTH-bit up-count from zero. The count
//               saturates at all ones, where K flags the final iteration.
//               The count then holds until the next load.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset (forces count to all ones)
//               load  - synchronous restart request
//               K     - terminal flag, high when the count is all ones
//               count - current count value (present only when the macro
//                       MULT_COUNTER_COUNT_EN is defined)
// Config      : MULT_COUNTER_COUNT_EN - exposes the internal count on 'count'
// Revision    : 1.0 - initial release
// ============================================================================
module mult_counter
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
`ifdef MULT_COUNTER_COUNT_EN
    output logic [WIDTH-1:0] count,
`endif
    output logic             K
);

    localparam logic [WIDTH-1:0] c_all_ones = '1;
    localparam logic [WIDTH-1:0] c_one      = WIDTH'(1);

    // Iteration count. Resets to all ones so the block reads as idle/done.
    logic [WIDTH-1:0] cont;

    // Load beats counting; at all ones the increment is never applied, so
    // the count saturates instead of wrapping back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cont <= c_all_ones;
        end else if (load) begin
            cont <= '0;
        end else if (cont != c_all_ones) begin
            cont <= cont + c_one;
        end
    end

    // Terminal flag depends on the count only, never directly on load.
    assign K = &cont;

`ifdef MULT_COUNTER_COUNT_EN
    assign count = cont;
`endif

endmodule : mult_counter
`default_nettype wire

// File: tb/tb_mult_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mult_counter
// Description : Directed self-checking bench for mult_counter (WIDTH=3,
//               4 ns clock). Expected counts are written out by hand.
//               Outputs are sampled 1 ns after each rising edge.
// Config      : MULT_COUNTER_COUNT_EN - also checks the 'count' port
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_counter;

    logic clk;
    logic rst_n;
    logic load;
    logic K;
`ifdef MULT_COUNTER_COUNT_EN
    logic [2:0] count;
`endif

    int checks = 0;
    int errors = 0;

    mult_counter #(.WIDTH(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
`ifdef MULT_COUNTER_COUNT_EN
        .count (count),
`endif
        .K     (K)
    );

    initial clk = 1'b0;
    always #2 clk = ~clk;

    // Compare the internal count, K and (when present) the count port.
    task automatic check(input string tag, input logic [2:0] exp_cont, input logic exp_k);
        checks++;
        assert (dut.cont === exp_cont) else begin
            errors++;
            $error("FAIL %s cont observed %0d expected %0d", tag, dut.cont, exp_cont);
        end
        checks++;
        assert (K === exp_k) else begin
            errors++;
            $error("FAIL %s K observed %0b expected %0b", tag, K, exp_k);
        end
`ifdef MULT_COUNTER_COUNT_EN
        checks++;
        assert (count === exp_cont) else begin
            errors++;
            $error("FAIL %s count observed %0d expected %0d", tag, count, exp_cont);
        end
`endif
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1. Reset held from t=0, then released with load low.
        rst_n = 1'b0;
        load  = 1'b0;
        step();
        check("reset", 3'd7, 1'b1);
        rst_n = 1'b1;
        step();
        check("post_reset_a", 3'd7, 1'b1);
        step();
        check("post_reset_b", 3'd7, 1'b1);

        // 2. Single-edge load: 0, then 1..6 with K low, 7 with K high, hold.
        load = 1'b1;
        step();
        check("load_edge", 3'd0, 1'b0);
        load = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            check("count_up", 3'(i), 1'b0);
        end
        step();
        check("terminal", 3'd7, 1'b1);
        step();
        check("saturate_a", 3'd7, 1'b1);
        step();
        check("saturate_b", 3'd7, 1'b1);

        // 3. Restart when the count reaches 4.
        load = 1'b1;
        step();
        check("restart_load", 3'd0, 1'b0);
        load = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            check("pre_restart", 3'(i), 1'b0);
        end
        load = 1'b1;
        step();
        check("restart_at_4", 3'd0, 1'b0);
        load = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            check("recount", 3'(i), 1'b0);
        end
        step();
        check("recount_term", 3'd7, 1'b1);

        // 4. Load held across three edges: stays 0, counting starts after.
        load = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("held_load", 3'd0, 1'b0);
        end
        load = 1'b0;
        step();
        check("after_held_1", 3'd1, 1'b0);
        step();
        check("after_held_2", 3'd2, 1'b0);
        step();
        check("after_held_3", 3'd3, 1'b0);

        // 5. Asynchronous reset between edges at count 3; load ignored in reset.
        #0.5;
        rst_n = 1'b0;
        #0.5;
        check("async_reset", 3'd7, 1'b1);
        load = 1'b1;
        step();
        check("load_in_reset", 3'd7, 1'b1);
        load  = 1'b0;
        rst_n = 1'b1;
        step();
        check("release_hold", 3'd7, 1'b1);
        load = 1'b1;
        step();
        check("load_after_rst", 3'd0, 1'b0);
        load = 1'b0;
        step();
        check("count_after_rst", 3'd1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mult_counter
`default_nettype wire
